// File: rtl/jtag_tap_oversampled.sv
// jtag_tap_oversampled: device-side IEEE 1149.1 TAP controller.
// The JTAG pins are oversampled in the core clock domain. The block holds the
// 16-state TAP FSM, the instruction register, IDCODE and BYPASS. Any other
// instruction is exposed through capture/shift/update strobes.
module jtag_tap_oversampled #(
  parameter int                           INSTRUCTION_WIDTH = 4,
  parameter logic [INSTRUCTION_WIDTH-1:0] IDCODE_INSTR      = 4'h1,
  parameter logic [INSTRUCTION_WIDTH-1:0] BYPASS_INSTR      = 4'hF,
  parameter logic [31:0]                  IDCODE_VALUE      = 32'h4e595a01
) (
  input  logic                         clk,
  input  logic                         reset_n,
  input  logic                         jtag_tck,
  input  logic                         jtag_tms,
  input  logic                         jtag_tdi,
  input  logic                         jtag_trst,
  output logic                         jtag_tdo,
  output logic [INSTRUCTION_WIDTH-1:0] instruction,
  output logic                         capture_dr,
  output logic                         shift_dr,
  output logic                         update_dr,
  output logic                         data_tdi,
  input  logic                         data_tdo
);

  typedef enum logic [3:0] {
    TLR, IDLE,
    SEL_DR, CAP_DR, SH_DR, EX1_DR, PAU_DR, EX2_DR, UPD_DR,
    SEL_IR, CAP_IR, SH_IR, EX1_IR, PAU_IR, EX2_IR, UPD_IR
  } tapState_t;

  logic [1:0]                   r_tckSync;
  logic [1:0]                   r_tmsSync;
  logic [1:0]                   r_tdiSync;
  logic [1:0]                   r_trstSync;
  logic                         r_tckPrev;
  tapState_t                    r_state;
  tapState_t                    w_nextState;
  logic [INSTRUCTION_WIDTH-1:0] r_instruction;
  logic [INSTRUCTION_WIDTH-1:0] r_irShift;
  logic [31:0]                  r_idShift;
  logic                         r_bypass;
  logic                         r_tdo;

  logic w_tck;
  logic w_tms;
  logic w_tdi;
  logic w_trst;
  logic w_tckRise;
  logic w_tckFall;
  logic w_isIdcode;
  logic w_isBypass;

  assign w_tck      = r_tckSync[1];
  assign w_tms      = r_tmsSync[1];
  assign w_tdi      = r_tdiSync[1];
  assign w_trst     = r_trstSync[1];
  assign w_tckRise  = w_tck & ~r_tckPrev;
  assign w_tckFall  = ~w_tck & r_tckPrev;
  assign w_isIdcode = (r_instruction == IDCODE_INSTR);
  assign w_isBypass = (r_instruction == BYPASS_INSTR);

  // Two-flop synchronizers for every pin, plus a delayed tck copy for edge detection.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_tckSync  <= '0;
      r_tmsSync  <= '0;
      r_tdiSync  <= '0;
      r_trstSync <= '0;
      r_tckPrev  <= 1'b0;
    end else begin
      r_tckSync  <= {r_tckSync[0], jtag_tck};
      r_tmsSync  <= {r_tmsSync[0], jtag_tms};
      r_tdiSync  <= {r_tdiSync[0], jtag_tdi};
      r_trstSync <= {r_trstSync[0], jtag_trst};
      r_tckPrev  <= r_tckSync[1];
    end
  end

  // TAP state register.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state <= TLR;
    end else begin
      r_state <= w_nextState;
    end
  end

  // Next-state logic: trst overrides everything, otherwise step on each tck rise.
  always_comb begin
    w_nextState = r_state;
    if (w_trst) begin
      w_nextState = TLR;
    end else if (w_tckRise) begin
      case (r_state)
        TLR:     w_nextState = w_tms ? TLR    : IDLE;
        IDLE:    w_nextState = w_tms ? SEL_DR : IDLE;
        SEL_DR:  w_nextState = w_tms ? SEL_IR : CAP_DR;
        CAP_DR:  w_nextState = w_tms ? EX1_DR : SH_DR;
        SH_DR:   w_nextState = w_tms ? EX1_DR : SH_DR;
        EX1_DR:  w_nextState = w_tms ? UPD_DR : PAU_DR;
        PAU_DR:  w_nextState = w_tms ? EX2_DR : PAU_DR;
        EX2_DR:  w_nextState = w_tms ? UPD_DR : SH_DR;
        UPD_DR:  w_nextState = w_tms ? SEL_DR : IDLE;
        SEL_IR:  w_nextState = w_tms ? TLR    : CAP_IR;
        CAP_IR:  w_nextState = w_tms ? EX1_IR : SH_IR;
        SH_IR:   w_nextState = w_tms ? EX1_IR : SH_IR;
        EX1_IR:  w_nextState = w_tms ? UPD_IR : PAU_IR;
        PAU_IR:  w_nextState = w_tms ? EX2_IR : PAU_IR;
        EX2_IR:  w_nextState = w_tms ? UPD_IR : SH_IR;
        UPD_IR:  w_nextState = w_tms ? SEL_DR : IDLE;
        default: w_nextState = TLR;
      endcase
    end
  end

  // Instruction, IR/DR shift registers and tdo; tdo only moves on tck falls.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_instruction <= IDCODE_INSTR;
      r_irShift     <= '0;
      r_idShift     <= '0;
      r_bypass      <= 1'b0;
      r_tdo         <= 1'b0;
    end else begin
      if (w_trst || r_state == TLR) begin
        r_instruction <= IDCODE_INSTR;
      end else if (w_tckRise && r_state == UPD_IR) begin
        r_instruction <= r_irShift;
      end

      if (w_tckRise && !w_trst) begin
        case (r_state)
          CAP_IR: r_irShift <= INSTRUCTION_WIDTH'(1);
          SH_IR:  r_irShift <= {w_tdi, r_irShift[INSTRUCTION_WIDTH-1:1]};
          CAP_DR: begin
            if (w_isIdcode) begin
              r_idShift <= IDCODE_VALUE;
            end else if (w_isBypass) begin
              r_bypass <= 1'b0;
            end
          end
          SH_DR: begin
            if (w_isIdcode) begin
              r_idShift <= {w_tdi, r_idShift[31:1]};
            end else if (w_isBypass) begin
              r_bypass <= w_tdi;
            end
          end
          default: begin
          end
        endcase
      end

      if (w_tckFall) begin
        case (r_state)
          SH_IR: r_tdo <= r_irShift[0];
          SH_DR: begin
            if (w_isIdcode) begin
              r_tdo <= r_idShift[0];
            end else if (w_isBypass) begin
              r_tdo <= r_bypass;
            end else begin
              r_tdo <= data_tdo;
            end
          end
          default: begin
          end
        endcase
      end
    end
  end

  assign capture_dr  = w_tckRise & ~w_trst & (r_state == CAP_DR);
  assign shift_dr    = w_tckRise & ~w_trst & (r_state == SH_DR);
  assign update_dr   = w_tckRise & ~w_trst & (r_state == UPD_DR);
  assign data_tdi    = w_tdi;
  assign jtag_tdo    = r_tdo;
  assign instruction = r_instruction;

endmodule

// File: tb/tb_jtag_tap_oversampled.sv
// tb_jtag_tap_oversampled: drives the TAP as a JTAG host with a tck divisor of
// 8 clk and compares scans against a scan-level reference model.
module tb_jtag_tap_oversampled;

  localparam int          W   = 4;
  localparam logic [3:0]  IDC = 4'h1;
  localparam logic [3:0]  BYP = 4'hF;
  localparam logic [31:0] IDV = 32'h4e595a01;

  logic       clk = 1'b0;
  logic       reset_n;
  logic       jtag_tck;
  logic       jtag_tms;
  logic       jtag_tdi;
  logic       jtag_trst;
  logic       jtag_tdo;
  logic [3:0] instruction;
  logic       capture_dr;
  logic       shift_dr;
  logic       update_dr;
  logic       data_tdi;
  logic       data_tdo;

  jtag_tap_oversampled dut (
    .clk         (clk),
    .reset_n     (reset_n),
    .jtag_tck    (jtag_tck),
    .jtag_tms    (jtag_tms),
    .jtag_tdi    (jtag_tdi),
    .jtag_trst   (jtag_trst),
    .jtag_tdo    (jtag_tdo),
    .instruction (instruction),
    .capture_dr  (capture_dr),
    .shift_dr    (shift_dr),
    .update_dr   (update_dr),
    .data_tdi    (data_tdi),
    .data_tdo    (data_tdo)
  );

  always #5 clk = ~clk;

  int         total = 0;
  int         bad   = 0;
  logic [3:0] modelInstr = IDC;
  logic       tdiVec[64];
  logic       dtdoVec[64];

  // Strobe monitor: counts high cycles and rising edges, and logs data_tdi per shift.
  int   capCycles = 0, shCycles = 0, updCycles = 0;
  int   capEdges = 0, shEdges = 0, updEdges = 0;
  logic prevCap = 1'b0, prevSh = 1'b0, prevUpd = 1'b0;
  logic tdiLog[1024];
  int   tdiLogCount = 0;

  always @(negedge clk) begin
    if (capture_dr === 1'b1) capCycles++;
    if (shift_dr === 1'b1) shCycles++;
    if (update_dr === 1'b1) updCycles++;
    if (capture_dr === 1'b1 && !prevCap) capEdges++;
    if (shift_dr === 1'b1 && !prevSh) shEdges++;
    if (update_dr === 1'b1 && !prevUpd) updEdges++;
    if (shift_dr === 1'b1) begin
      if (tdiLogCount < 1024) tdiLog[tdiLogCount] = data_tdi;
      tdiLogCount++;
    end
    prevCap = (capture_dr === 1'b1);
    prevSh  = (shift_dr === 1'b1);
    prevUpd = (update_dr === 1'b1);
  end

  // Reference: expected tdo bits of an n-bit DR scan for the current instruction.
  function automatic logic [63:0] modelDr(input int n);
    logic [63:0] e;
    logic [31:0] idv;
    idv = IDV;
    e = '0;
    for (int i = 0; i < n; i++) begin
      if (modelInstr == IDC) e[i] = (i < 32) ? idv[i] : tdiVec[i-32];
      else if (modelInstr == BYP) e[i] = (i == 0) ? 1'b0 : tdiVec[i-1];
      else e[i] = dtdoVec[i];
    end
    return e;
  endfunction

  // One tck period: low half then high half, 4 clk each; tdo sampled just before the rise.
  task automatic tckCycle(input logic tmsV, input logic tdiV, input logic dtdoV,
                          output logic tdoV);
    jtag_tms = tmsV;
    jtag_tdi = tdiV;
    data_tdo = dtdoV;
    jtag_tck = 1'b0;
    repeat (4) @(posedge clk);
    #1;
    tdoV = jtag_tdo;
    jtag_tck = 1'b1;
    repeat (4) @(posedge clk);
    #1;
  endtask

  task automatic applyStimulus();
    for (int i = 0; i < 64; i++) begin
      tdiVec[i]  = 1'($urandom_range(0, 1));
      dtdoVec[i] = 1'($urandom_range(0, 1));
    end
  endtask

  task automatic goIdle();
    logic t;
    for (int i = 0; i < 5; i++) tckCycle(1'b1, 1'b0, 1'b0, t);
    tckCycle(1'b0, 1'b0, 1'b0, t);
  endtask

  // IR scan from IDLE back to IDLE; returns the bits seen on tdo.
  task automatic irScan(input logic [3:0] v, output logic [3:0] got);
    logic t;
    got = '0;
    tckCycle(1'b1, 1'b0, 1'b0, t);
    tckCycle(1'b1, 1'b0, 1'b0, t);
    tckCycle(1'b0, 1'b0, 1'b0, t);
    tckCycle(1'b0, 1'b0, 1'b0, t);
    for (int i = 0; i < W; i++) begin
      tckCycle(i == W - 1, v[i], 1'b0, t);
      got[i] = t;
    end
    tckCycle(1'b1, 1'b0, 1'b0, t);
    tckCycle(1'b0, 1'b0, 1'b0, t);
    modelInstr = v;
  endtask

  // DR scan of n bits from IDLE back to IDLE using tdiVec/dtdoVec.
  task automatic drScan(input int n, output logic [63:0] got);
    logic t;
    got = '0;
    tckCycle(1'b1, 1'b0, 1'b0, t);
    tckCycle(1'b0, 1'b0, 1'b0, t);
    tckCycle(1'b0, 1'b0, 1'b0, t);
    for (int i = 0; i < n; i++) begin
      tckCycle(i == n - 1, tdiVec[i], dtdoVec[i], t);
      got[i] = t;
    end
    tckCycle(1'b1, 1'b0, 1'b0, t);
    tckCycle(1'b0, 1'b0, 1'b0, t);
  endtask

  task automatic test_reset();
    reset_n = 1'b0; jtag_tck = 1'b0; jtag_tms = 1'b1; jtag_tdi = 1'b1;
    jtag_trst = 1'b0; data_tdo = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    total++; if (jtag_tdo !== 1'b0) begin bad++; $display("[TB] FAIL reset_tdo got=%0b exp=0", jtag_tdo); end
    total++; if (instruction !== IDC) begin bad++; $display("[TB] FAIL reset_instr got=%0h exp=%0h", instruction, IDC); end
    total++; if ({capture_dr, shift_dr, update_dr} !== 3'b000) begin bad++; $display("[TB] FAIL reset_strobes got=%0b exp=000", {capture_dr, shift_dr, update_dr}); end
    total++; if (data_tdi !== 1'b0) begin bad++; $display("[TB] FAIL reset_data_tdi got=%0b exp=0", data_tdi); end
    reset_n = 1'b1;
    repeat (2) @(posedge clk);
    #1;
  endtask

  task automatic test_idcode();
    logic [63:0] got;
    int          shSnap;
    goIdle();
    total++; if (instruction !== IDC) begin bad++; $display("[TB] FAIL idle_instr got=%0h exp=%0h", instruction, IDC); end
    applyStimulus();
    shSnap = shCycles;
    drScan(32, got);
    total++; if (got[31:0] !== 32'h4e595a01) begin bad++; $display("[TB] FAIL idcode_value got=%0h exp=4e595a01", got[31:0]); end
    total++; if (shCycles - shSnap !== 32) begin bad++; $display("[TB] FAIL idcode_shift_count got=%0d exp=32", shCycles - shSnap); end
    applyStimulus();
    drScan(40, got);
    total++; if (got !== modelDr(40)) begin bad++; $display("[TB] FAIL idcode_40 got=%0h exp=%0h", got, modelDr(40)); end
  endtask

  task automatic test_ir_scan();
    logic [3:0] got;
    irScan(4'h3, got);
    total++; if (got !== 4'b0001) begin bad++; $display("[TB] FAIL ir_capture got=%0b exp=0001", got); end
    total++; if (instruction !== 4'h3) begin bad++; $display("[TB] FAIL ir_update got=%0h exp=3", instruction); end
  endtask

  task automatic test_bypass();
    logic [3:0]  g4;
    logic [63:0] got;
    irScan(BYP, g4);
    total++; if (instruction !== BYP) begin bad++; $display("[TB] FAIL bypass_instr got=%0h exp=%0h", instruction, BYP); end
    applyStimulus();
    tdiVec[0] = 1'b1; tdiVec[1] = 1'b0; tdiVec[2] = 1'b1; tdiVec[3] = 1'b1;
    drScan(4, got);
    total++; if (got[3:0] !== 4'b1010) begin bad++; $display("[TB] FAIL bypass_fixed got=%0b exp=1010", got[3:0]); end
    applyStimulus();
    drScan(20, got);
    total++; if (got !== modelDr(20)) begin bad++; $display("[TB] FAIL bypass_rand got=%0h exp=%0h", got, modelDr(20)); end
  endtask

  task automatic test_user_dr();
    logic [3:0]  g4;
    logic [63:0] got, gotTdi, expTdi, expTdo;
    int          capS, shS, updS, capE, shE, updE, logS;
    irScan(4'h3, g4);
    applyStimulus();
    capS = capCycles; shS = shCycles; updS = updCycles;
    capE = capEdges;  shE = shEdges;  updE = updEdges;
    logS = tdiLogCount;
    drScan(40, got);
    total++; if (capCycles - capS !== 1 || capEdges - capE !== 1) begin bad++; $display("[TB] FAIL user_capture cycles=%0d pulses=%0d exp=1/1", capCycles - capS, capEdges - capE); end
    total++; if (shCycles - shS !== 40 || shEdges - shE !== 40) begin bad++; $display("[TB] FAIL user_shift cycles=%0d pulses=%0d exp=40/40", shCycles - shS, shEdges - shE); end
    total++; if (updCycles - updS !== 1 || updEdges - updE !== 1) begin bad++; $display("[TB] FAIL user_update cycles=%0d pulses=%0d exp=1/1", updCycles - updS, updEdges - updE); end
    gotTdi = '0; expTdi = '0; expTdo = '0;
    for (int i = 0; i < 40; i++) begin
      if (logS + i < 1024) gotTdi[i] = tdiLog[logS + i];
      expTdi[i] = tdiVec[i];
      expTdo[i] = dtdoVec[i];
    end
    total++; if (gotTdi !== expTdi) begin bad++; $display("[TB] FAIL user_data_tdi got=%0h exp=%0h", gotTdi, expTdi); end
    total++; if (got !== expTdo) begin bad++; $display("[TB] FAIL user_tdo got=%0h exp=%0h", got, expTdo); end
    total++; if (got !== modelDr(40)) begin bad++; $display("[TB] FAIL user_model got=%0h exp=%0h", got, modelDr(40)); end
  endtask

  task automatic test_random();
    logic [3:0]  v, g4;
    logic [63:0] got;
    int          n;
    for (int k = 0; k < 8; k++) begin
      case ($urandom_range(0, 3))
        0:       v = IDC;
        1:       v = BYP;
        default: v = 4'($urandom_range(0, 15));
      endcase
      irScan(v, g4);
      total++; if (g4 !== 4'b0001 || instruction !== v) begin bad++; $display("[TB] FAIL rand_ir[%0d] tdo=%0b instr=%0h exp=0001/%0h", k, g4, instruction, v); end
      n = $urandom_range(1, 48);
      applyStimulus();
      drScan(n, got);
      total++; if (got !== modelDr(n)) begin bad++; $display("[TB] FAIL rand_dr[%0d] n=%0d got=%0h exp=%0h", k, n, got, modelDr(n)); end
    end
  endtask

  task automatic test_trst();
    logic [3:0]  g4;
    logic [63:0] got;
    logic        t;
    int          capS, shS, updS;
    irScan(4'h3, g4);
    total++; if (instruction !== 4'h3) begin bad++; $display("[TB] FAIL trst_pre_instr got=%0h exp=3", instruction); end
    tckCycle(1'b1, 1'b0, 1'b0, t);
    tckCycle(1'b0, 1'b0, 1'b0, t);
    tckCycle(1'b0, 1'b0, 1'b0, t);
    for (int i = 0; i < 5; i++) tckCycle(1'b0, 1'($urandom_range(0, 1)), 1'b0, t);
    capS = capCycles; shS = shCycles; updS = updCycles;
    jtag_tms = 1'b0;
    jtag_tck = 1'b0;
    repeat (4) @(posedge clk);
    #1;
    jtag_tck  = 1'b1;
    jtag_trst = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    total++; if (instruction !== IDC) begin bad++; $display("[TB] FAIL trst_instr got=%0h exp=%0h", instruction, IDC); end
    repeat (4) @(posedge clk);
    #1;
    jtag_trst = 1'b0;
    repeat (4) @(posedge clk);
    #1;
    total++; if (capCycles != capS || shCycles != shS || updCycles != updS) begin bad++; $display("[TB] FAIL trst_strobes cap=%0d sh=%0d upd=%0d exp=0/0/0", capCycles - capS, shCycles - shS, updCycles - updS); end
    modelInstr = IDC;
    tckCycle(1'b1, 1'b0, 1'b0, t);
    tckCycle(1'b1, 1'b0, 1'b0, t);
    total++; if (instruction !== IDC) begin bad++; $display("[TB] FAIL trst_tlr_hold got=%0h exp=%0h", instruction, IDC); end
    tckCycle(1'b0, 1'b0, 1'b0, t);
    applyStimulus();
    drScan(32, got);
    total++; if (got !== modelDr(32)) begin bad++; $display("[TB] FAIL trst_idcode got=%0h exp=%0h", got, modelDr(32)); end
  endtask

  task automatic test_reset_mid_ir();
    logic [3:0]  g4;
    logic [63:0] got;
    logic        t;
    irScan(4'h3, g4);
    tckCycle(1'b1, 1'b0, 1'b0, t);
    tckCycle(1'b1, 1'b0, 1'b0, t);
    tckCycle(1'b0, 1'b0, 1'b0, t);
    tckCycle(1'b0, 1'b0, 1'b0, t);
    jtag_tms = 1'b0;
    jtag_tdi = 1'b1;
    jtag_tck = 1'b0;
    repeat (4) @(posedge clk);
    #1;
    total++; if (jtag_tdo !== 1'b1) begin bad++; $display("[TB] FAIL mid_ir_tdo got=%0b exp=1", jtag_tdo); end
    #2;
    reset_n = 1'b0;
    #1;
    total++; if (jtag_tdo !== 1'b0 || instruction !== IDC) begin bad++; $display("[TB] FAIL async_reset tdo=%0b instr=%0h exp=0/%0h", jtag_tdo, instruction, IDC); end
    total++; if ({capture_dr, shift_dr, update_dr, data_tdi} !== 4'b0000) begin bad++; $display("[TB] FAIL async_reset_strobes got=%0b exp=0000", {capture_dr, shift_dr, update_dr, data_tdi}); end
    jtag_tms = 1'b1;
    repeat (3) @(posedge clk);
    #3;
    reset_n = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    modelInstr = IDC;
    for (int i = 0; i < 3; i++) tckCycle(1'b1, 1'($urandom_range(0, 1)), 1'b0, t);
    total++; if (instruction !== IDC) begin bad++; $display("[TB] FAIL post_reset_instr got=%0h exp=%0h", instruction, IDC); end
    tckCycle(1'b0, 1'b0, 1'b0, t);
    applyStimulus();
    drScan(32, got);
    total++; if (got !== modelDr(32)) begin bad++; $display("[TB] FAIL post_reset_idcode got=%0h exp=%0h", got, modelDr(32)); end
  endtask

  // Scenario sequence followed by the summary line.
  initial begin
    test_reset();
    test_idcode();
    test_ir_scan();
    test_bypass();
    test_user_dr();
    test_random();
    test_trst();
    test_reset_mid_ir();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
